// File: rtl/snoop_loader_if.sv
// snoop_loader_if: byte-stream input and snoop-port output of the program loader.
//   slave  : the loader (consumes the byte stream, drives snoop port and status)
//   master : the stream source / core side (drives bytes, observes everything else)
// Signals:
//   in_valid, in_data[7:0], in_ready     byte stream handshake
//   snoopa[7:0], snoopd[7:0], snoopp     snoop write address / data / enable
//   cpu_reset, load_ok, load_err         core reset and sticky load status
interface snoop_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic       snoopp;
  logic       cpu_reset;
  logic       load_ok;
  logic       load_err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, snoopa, snoopd, snoopp, cpu_reset, load_ok, load_err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, snoopa, snoopd, snoopp, cpu_reset, load_ok, load_err
  );
endinterface

// File: rtl/snoop_loader.sv
// snoop_loader: framed program loader in front of the discus core snoop port.
// Frame: SYNC, length L (0 = 256), L payload bytes, checksum byte C.
// Payload is written to addresses 0..L-1, one snoop write per byte, one cycle
// after the byte is accepted. The core is held in reset for the whole load and
// released only when (sum(payload) + C) mod 256 == 0.
// Ports:
//   clk    single clock (also the core's snoop_clk)
//   reset  synchronous, active-high
//   bus    snoop_loader_if.slave (stream in, snoop write + status out)
module snoop_loader #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  snoop_loader_if.slave  bus
);

  localparam logic [2:0] HUNT = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] CSUM = 3'd3;
  localparam logic [2:0] RUN  = 3'd4;

  logic [2:0] state;
  logic [7:0] acc;
  logic [7:0] addr;
  logic [8:0] cnt;
  logic       accept;
  logic [7:0] sum;

  // in_ready is itself registered, so nothing is accepted during reset.
  assign accept = bus.in_valid && bus.in_ready;
  assign sum    = acc + bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      acc           <= '0;
      addr          <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.snoopp    <= 1'b0;
      bus.snoopa    <= '0;
      bus.snoopd    <= '0;
      bus.cpu_reset <= 1'b1;
      bus.load_ok   <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      bus.in_ready <= 1'b1;
      bus.snoopp   <= 1'b0;
      if (accept) begin
        case (state)
          HUNT, RUN: begin
            // Reload from either state; holding the core again is what makes
            // a reload in RUN safe.
            if (bus.in_data == SYNC) begin
              state         <= LEN;
              bus.cpu_reset <= 1'b1;
              bus.load_ok   <= 1'b0;
              bus.load_err  <= 1'b0;
              acc           <= '0;
              addr          <= '0;
            end
          end
          LEN: begin
            // L=0 encodes 256: set bit 8 exactly when the low byte is zero.
            cnt   <= {(bus.in_data == 8'h00), bus.in_data};
            state <= DATA;
          end
          DATA: begin
            bus.snoopp <= 1'b1;
            bus.snoopa <= addr;
            bus.snoopd <= bus.in_data;
            acc        <= sum;
            addr       <= addr + 8'd1;
            cnt        <= cnt - 9'd1;
            if (cnt == 9'd1) state <= CSUM;
          end
          CSUM: begin
            acc <= sum;
            if (sum == 8'h00) begin
              state         <= RUN;
              bus.load_ok   <= 1'b1;
              bus.cpu_reset <= 1'b0;
            end else begin
              state        <= HUNT;
              bus.load_err <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snoop_loader.sv
module tb_snoop_loader;
  logic clk;
  logic reset;
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;
  int   viol;

  snoop_loader_if bus ();

  snoop_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  initial viol = 0;
  always @(negedge clk) begin
    if (bus.snoopp === 1'b1) begin
      wa.push_back(bus.snoopa);
      wd.push_back(bus.snoopd);
      wc.push_back(cyc);
      if (bus.cpu_reset !== 1'b1) viol++;
    end
  end

  // Frame A payload; sum = 0xEC so good checksum is 0x14.
  logic [7:0] pa [12];
  initial begin
    pa[0] = 8'h50; pa[1] = 8'hE8; pa[2]  = 8'h91; pa[3]  = 8'hDA;
    pa[4] = 8'h0B; pa[5] = 8'h10; pa[6]  = 8'h43; pa[7]  = 8'hE8;
    pa[8] = 8'hC9; pa[9] = 8'hC9; pa[10] = 8'hC9; pa[11] = 8'hA8;
  end
  localparam logic [7:0] CS_A = 8'h14;

  // Tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b, output int c);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    c = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic send_frame_a(input logic [7:0] cs);
    int c;
    send_byte(8'hA5, c);
    send_byte(8'h0C, c);
    for (int i = 0; i < 12; i++) send_byte(pa[i], c);
    send_byte(cs, c);
  endtask

  task automatic check_log_a(input string tag);
    int bad;
    int first;
    chk_cnt++;
    if (wa.size() !== 12) $display("FAIL %s_count: got %0d writes want 12", tag, wa.size());
    else pass_cnt++;
    bad = 0; first = -1;
    for (int i = 0; i < wa.size() && i < 12; i++)
      if (wa[i] !== 8'(i) || wd[i] !== pa[i] || wc[i] !== wc[0] + i) begin
        bad++;
        if (first < 0) first = i;
      end
    chk_cnt++;
    if (bad != 0)
      $display("FAIL %s_writes: entry %0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
               tag, first, wa[first], wd[first], wc[first], 8'(first), pa[first], wc[0] + first);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.in_ready, bus.cpu_reset, bus.snoopp, bus.load_ok, bus.load_err} !== 5'b01000)
      $display("FAIL reset_ctrl: got rdy/cpu/p/ok/err=%b want 01000",
               {bus.in_ready, bus.cpu_reset, bus.snoopp, bus.load_ok, bus.load_err});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.snoopa, bus.snoopd} !== 16'h0000)
      $display("FAIL reset_addr_data: got a=%h d=%h want 00 00", bus.snoopa, bus.snoopd);
    else pass_cnt++;
    idle(1);
    reset = 1'b0;
    idle(1);
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_good_frame();
    int c;
    clear_log();
    send_byte(8'hA5, c);
    send_byte(8'h0C, c);
    for (int i = 0; i < 12; i++) send_byte(pa[i], c);
    chk_cnt++;
    if (bus.cpu_reset !== 1'b1) $display("FAIL good_hold: cpu_reset got %b want 1", bus.cpu_reset);
    else pass_cnt++;
    send_byte(CS_A, c);
    chk_cnt++;
    if ({bus.cpu_reset, bus.load_ok, bus.load_err} !== 3'b010)
      $display("FAIL good_release: cpu/ok/err got %b want 010",
               {bus.cpu_reset, bus.load_ok, bus.load_err});
    else pass_cnt++;
    check_log_a("good");
    // Non-SYNC bytes in RUN are ignored.
    clear_log();
    send_byte(8'h00, c);
    send_byte(8'h0C, c);
    idle(2);
    chk_cnt++;
    if (wa.size() !== 0 || bus.cpu_reset !== 1'b0 || bus.load_ok !== 1'b1)
      $display("FAIL run_ignore: writes=%0d cpu=%b ok=%b want 0 0 1", wa.size(), bus.cpu_reset, bus.load_ok);
    else pass_cnt++;
  endtask

  task automatic test_bad_frame();
    int c;
    clear_log();
    send_frame_a(CS_A + 8'd1);
    idle(1);
    chk_cnt++;
    if ({bus.cpu_reset, bus.load_ok, bus.load_err} !== 3'b101)
      $display("FAIL bad_status: cpu/ok/err got %b want 101",
               {bus.cpu_reset, bus.load_ok, bus.load_err});
    else pass_cnt++;
    check_log_a("bad");
    // Back in HUNT: a length-like byte must not start a frame.
    clear_log();
    send_byte(8'h02, c);
    send_byte(8'h11, c);
    send_byte(8'h22, c);
    idle(2);
    chk_cnt++;
    if (wa.size() !== 0) $display("FAIL bad_hunt: got %0d writes want 0", wa.size());
    else pass_cnt++;
    send_byte(8'hA5, c);
    chk_cnt++;
    if (bus.load_err !== 1'b0) $display("FAIL err_clear: load_err got %b want 0", bus.load_err);
    else pass_cnt++;
    send_byte(8'h0C, c);
    for (int i = 0; i < 12; i++) send_byte(pa[i], c);
    send_byte(CS_A, c);
    chk_cnt++;
    if ({bus.cpu_reset, bus.load_ok, bus.load_err} !== 3'b010)
      $display("FAIL reload_release: cpu/ok/err got %b want 010",
               {bus.cpu_reset, bus.load_ok, bus.load_err});
    else pass_cnt++;
  endtask

  // Garbage then a gapped 4-byte frame whose payload contains SYNC as data.
  task automatic test_gaps();
    int c;
    int ac[4];
    logic [7:0] pl[4];
    int bad;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'hA5;  // sum 0xAB
    clear_log();
    // Core is in RUN; garbage is ignored there too, then SYNC reloads.
    send_byte(8'h00, c); idle(1);
    send_byte(8'hFF, c);
    send_byte(8'h12, c); idle(2);
    send_byte(8'hA5, c); idle($urandom_range(0, 3));
    chk_cnt++;
    if (bus.cpu_reset !== 1'b1) $display("FAIL gap_sync_hold: cpu_reset got %b want 1", bus.cpu_reset);
    else pass_cnt++;
    send_byte(8'h04, c); idle($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) begin
      send_byte(pl[i], c);
      ac[i] = c;
      idle($urandom_range(0, 3));
    end
    chk_cnt++;
    if (wa.size() !== 4) $display("FAIL gap_count: got %0d writes want 4", wa.size());
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 4 && i < wa.size(); i++)
      if (wa[i] !== 8'(i) || wd[i] !== pl[i] || wc[i] !== ac[i]) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL gap_writes: %0d of 4 writes wrong addr/data/timing want 0", bad);
    else pass_cnt++;
    send_byte(8'h55, c);
    chk_cnt++;
    if ({bus.cpu_reset, bus.load_ok} !== 2'b01)
      $display("FAIL gap_release: cpu/ok got %b want 01", {bus.cpu_reset, bus.load_ok});
    else pass_cnt++;
  endtask

  // L=0: 256 bytes 0..255, sum 0x80, check byte 0x80.
  task automatic test_full_256();
    int c;
    int bad;
    int first;
    clear_log();
    send_byte(8'hA5, c);
    send_byte(8'h00, c);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), c);
      if (i == 254) begin
        chk_cnt++;
        if (bus.cpu_reset !== 1'b1) $display("FAIL full_early: cpu_reset got %b want 1 before last byte", bus.cpu_reset);
        else pass_cnt++;
      end
    end
    send_byte(8'h80, c);
    chk_cnt++;
    if ({bus.cpu_reset, bus.load_ok, bus.load_err} !== 3'b010)
      $display("FAIL full_release: cpu/ok/err got %b want 010",
               {bus.cpu_reset, bus.load_ok, bus.load_err});
    else pass_cnt++;
    chk_cnt++;
    if (wa.size() !== 256) $display("FAIL full_count: got %0d writes want 256", wa.size());
    else pass_cnt++;
    bad = 0; first = 0;
    for (int i = 0; i < wa.size() && i < 256; i++)
      if (wa[i] !== 8'(i) || wd[i] !== 8'(i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    chk_cnt++;
    if (bad != 0) $display("FAIL full_writes: %0d bad, first at %0d got a=%h d=%h", bad, first, wa[first], wd[first]);
    else pass_cnt++;
  endtask

  task automatic test_sync_then_reset();
    int c;
    clear_log();
    send_byte(8'hA5, c);
    chk_cnt++;
    if ({bus.cpu_reset, bus.load_ok} !== 2'b10)
      $display("FAIL run_sync: cpu/ok got %b want 10", {bus.cpu_reset, bus.load_ok});
    else pass_cnt++;
    send_byte(8'h08, c);
    send_byte(8'h31, c);
    send_byte(8'h32, c);
    send_byte(8'h33, c);
    // Abort mid-frame while the stream keeps coming.
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h34;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.snoopp, bus.cpu_reset, bus.load_ok, bus.load_err, bus.in_ready} !== 5'b01000)
      $display("FAIL midreset: p/cpu/ok/err/rdy got %b want 01000",
               {bus.snoopp, bus.cpu_reset, bus.load_ok, bus.load_err, bus.in_ready});
    else pass_cnt++;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), c);
    idle(2);
    chk_cnt++;
    if (wa.size() !== 3) $display("FAIL midreset_writes: got %0d writes want 3", wa.size());
    else pass_cnt++;
    chk_cnt++;
    if (wa.size() == 3 && (wd[0] !== 8'h31 || wd[2] !== 8'h33 || wa[2] !== 8'h02))
      $display("FAIL midreset_data: got d0=%h d2=%h a2=%h want 31 33 02", wd[0], wd[2], wa[2]);
    else pass_cnt++;
    chk_cnt++;
    if (bus.cpu_reset !== 1'b1) $display("FAIL midreset_hold: cpu_reset got %b want 1", bus.cpu_reset);
    else pass_cnt++;
  endtask

  task automatic test_no_write_while_running();
    chk_cnt++;
    if (viol !== 0) $display("FAIL write_while_run: got %0d writes with cpu_reset=0 want 0", viol);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_gaps();
    test_full_256();
    test_sync_then_reset();
    test_no_write_while_running();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
